// File: rtl/adder_stim_gen.sv
// Operand source and in-order result checker for a signed adder.
// A start request waits a gap, then emits a burst of LFSR operand pairs.
// Expected sums are queued, and returned results are compared in order.
module adder_stim_gen #(
    parameter int          DW         = 8,
    parameter int          BURST_LEN  = 20,
    parameter int          GAP        = 20,
    parameter int          FIFO_DEPTH = 8,
    parameter int          TIMEOUT    = 64,
    parameter logic [15:0] SEED_A     = 16'hACE1,
    parameter logic [15:0] SEED_B     = 16'h1D2B
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [DW-1:0] din_a,
    output logic [DW-1:0] din_b,
    output logic          din_vld,
    input  logic [DW:0]   dout0,
    input  logic          dout_vld,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          ovf,
    output logic [15:0]   err_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GAP   = 3'd1;
    localparam logic [2:0] S_BURST = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state, state_next;
    logic [15:0]   cnt;
    logic [15:0]   lfsr_a, lfsr_b;
    logic [DW:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;

    logic          start_acc, emit, fifo_empty, fifo_full;
    logic          pop, push, drop, timeout;
    logic [DW:0]   exp_sum;
    logic [16:0]   err_inc, err_sum;
    logic [15:0]   err_next;

    // Next-state, FIFO handshake and error accounting for this cycle.
    always_comb begin
        start_acc  = (state == S_IDLE) && start;
        emit       = (state == S_BURST);
        fifo_empty = (count == '0);
        fifo_full  = (count == CW'(FIFO_DEPTH));
        pop        = dout_vld && !fifo_empty;
        // A full FIFO can still take the push when the head leaves this cycle.
        drop       = emit && fifo_full && !pop;
        push       = emit && !drop;
        timeout    = (state == S_DRAIN) && !fifo_empty && !dout_vld &&
                     (cnt == 16'(TIMEOUT - 1));
        exp_sum    = {lfsr_a[DW-1], lfsr_a[DW-1:0]} + {lfsr_b[DW-1], lfsr_b[DW-1:0]};

        err_inc = '0;
        if (dout_vld && fifo_empty)        err_inc = err_inc + 17'd1;
        if (pop && (mem[rptr] != dout0))   err_inc = err_inc + 17'd1;
        if (drop)                          err_inc = err_inc + 17'd1;
        if (timeout)                       err_inc = err_inc + 17'(count);
        err_sum  = {1'b0, err_cnt} + err_inc;
        err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];

        state_next = state;
        case (state)
            S_IDLE:  if (start)                       state_next = S_GAP;
            S_GAP:   if (cnt == 16'(GAP - 1))         state_next = S_BURST;
            S_BURST: if (cnt == 16'(BURST_LEN - 1))   state_next = S_DRAIN;
            S_DRAIN: if (fifo_empty || timeout)       state_next = S_DONE;
            S_DONE:                                   state_next = S_IDLE;
            default:                                  state_next = S_IDLE;
        endcase
    end

    // Sequencer state; cnt is the phase counter, and in DRAIN the idle-result counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || state == S_IDLE)
                cnt <= '0;
            else if (state == S_DRAIN && dout_vld)
                cnt <= '0;
            else
                cnt <= cnt + 16'd1;
        end
    end

    // Operand LFSRs advance only when a pair is emitted; outputs are zero when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_a  <= SEED_A;
            lfsr_b  <= SEED_B;
            din_vld <= 1'b0;
            din_a   <= '0;
            din_b   <= '0;
        end else begin
            din_vld <= emit;
            din_a   <= emit ? lfsr_a[DW-1:0] : '0;
            din_b   <= emit ? lfsr_b[DW-1:0] : '0;
            if (start_acc) begin
                lfsr_a <= SEED_A;
                lfsr_b <= SEED_B;
            end else if (emit) begin
                lfsr_a <= {lfsr_a[14:0], lfsr_a[15] ^ lfsr_a[13] ^ lfsr_a[12] ^ lfsr_a[10]};
                lfsr_b <= {lfsr_b[14:0], lfsr_b[15] ^ lfsr_b[13] ^ lfsr_b[12] ^ lfsr_b[10]};
            end
        end
    end

    // Expected-sum storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= exp_sum;
    end

    // Queue pointers and occupancy; a timeout discards everything outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (timeout) begin
            rptr  <= wptr;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Run status: error count, overflow, and the end-of-run verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            ovf     <= 1'b0;
            pass    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            busy <= (state_next != S_IDLE);
            done <= (state_next == S_DONE);
            if (start_acc) begin
                err_cnt <= '0;
                ovf     <= 1'b0;
                pass    <= 1'b0;
            end else begin
                err_cnt <= err_next;
                if (drop) ovf <= 1'b1;
                if (state_next == S_DONE) pass <= (err_next == 16'd0);
            end
        end
    end

endmodule

// File: tb/tb_adder_stim_gen.sv
// Bench for adder_stim_gen: a configurable adder stand-in closes the loop,
// and a queue-based model of the run timeline is checked every cycle.
module tb_adder_stim_gen;

    localparam int          DW         = 8;
    localparam int          BURST_LEN  = 20;
    localparam int          GAP        = 20;
    localparam int          FIFO_DEPTH = 8;
    localparam int          TIMEOUT    = 64;
    localparam logic [15:0] SEED_A     = 16'hACE1;
    localparam logic [15:0] SEED_B     = 16'h1D2B;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] din_a, din_b;
    logic          din_vld;
    logic [DW:0]   dout0;
    logic          dout_vld;
    logic          busy, done, pass, ovf;
    logic [15:0]   err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    adder_stim_gen #(
        .DW(DW), .BURST_LEN(BURST_LEN), .GAP(GAP), .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT(TIMEOUT), .SEED_A(SEED_A), .SEED_B(SEED_B)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .din_a(din_a), .din_b(din_b), .din_vld(din_vld),
        .dout0(dout0), .dout_vld(dout_vld),
        .busy(busy), .done(done), .pass(pass), .ovf(ovf), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Adder stand-in: fixed latency, optional corruption of one result.
    int          lat     = 1;
    int          bad_idx = -1;
    bit          add_en  = 1'b1;
    bit          inj     = 1'b0;
    int          nres;
    logic [15:0] pv;
    logic [DW:0] pd [16];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv   <= '0;
            nres <= 0;
        end else begin
            pv <= {pv[14:0], din_vld && add_en};
            for (int i = 15; i > 0; i--) pd[i] <= pd[i-1];
            pd[0] <= (DW+1)'($signed(din_a)) + (DW+1)'($signed(din_b)) +
                     (DW+1)'(din_vld && (nres == bad_idx));
            if (din_vld) nres <= nres + 1;
        end
    end

    assign dout_vld = pv[lat-1] | inj;
    assign dout0    = pd[lat-1];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: run timeline in cycles since start, expected sums in a queue.
    logic [15:0]        m_la, m_lb;
    logic signed [DW:0] m_q [$];
    bit                 m_active, m_fin;
    int                 m_t, m_idle, m_err;
    bit                 m_ovf, m_pass, m_done, m_busy, m_vld;
    logic [DW-1:0]      m_a, m_b;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_la = SEED_A; m_lb = SEED_B;
        m_active = 0; m_fin = 0; m_t = 0; m_idle = 0; m_err = 0;
        m_ovf = 0; m_pass = 0; m_done = 0; m_busy = 0; m_vld = 0;
        m_a = '0; m_b = '0;
    endtask

    task automatic model_step();
        int sz0, inc;
        bit fin;
        logic signed [DW:0] head, s;
        sz0 = m_q.size(); inc = 0; fin = 0;
        if (dout_vld) begin
            if (sz0 == 0) inc++;
            else begin
                head = m_q.pop_front();
                if (head !== dout0) inc++;
            end
        end
        m_vld = 0; m_a = '0; m_b = '0; m_done = 0;
        if (!m_active) begin
            if (start) begin
                m_active = 1; m_t = 0; m_idle = 0;
                m_la = SEED_A; m_lb = SEED_B;
                m_err = 0; m_ovf = 0; m_pass = 0; inc = 0;
            end
        end else if (m_fin) begin
            m_active = 0; m_fin = 0;
        end else begin
            m_t++;
            if (m_t >= GAP + 1 && m_t <= GAP + BURST_LEN) begin
                m_vld = 1; m_a = m_la[DW-1:0]; m_b = m_lb[DW-1:0];
                s = $signed(m_a) + $signed(m_b);
                if (m_q.size() == FIFO_DEPTH) begin inc++; m_ovf = 1; end
                else m_q.push_back(s);
                m_la = lfsr_step(m_la); m_lb = lfsr_step(m_lb);
            end else if (m_t > GAP + BURST_LEN) begin
                if (sz0 == 0) fin = 1;
                else if (!dout_vld && m_idle == TIMEOUT - 1) begin
                    inc += m_q.size(); m_q.delete(); fin = 1;
                end else if (dout_vld) m_idle = 0;
                else m_idle++;
            end
        end
        m_err = (m_err + inc > 65535) ? 65535 : m_err + inc;
        if (fin) begin m_done = 1; m_pass = (m_err == 0); m_fin = 1; end
        m_busy = m_active;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("outputs", {din_vld, din_a, din_b, busy, done, pass, ovf, err_cnt},
                  {m_vld, m_a, m_b, m_busy, m_done, m_pass, m_ovf, 16'(m_err)});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Returns the negedge index (1 = first after start) of the first din_vld.
    task automatic wait_first(output int k);
        k = 1;
        while (!din_vld && k < 300) begin @(negedge clk); k++; end
    endtask

    task automatic wait_done(input bit stray);
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (done) begin seen = 1; start = 1'b0; end
            else begin
                start = stray && ($urandom_range(0, 7) == 0);
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("done_pulse", seen, 1);
    endtask

    initial begin
        int k, nv;
        rst_n = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {din_vld, din_a, din_b, busy, done, pass, ovf, err_cnt}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: clean loopback
        lat = 1; bad_idx = -1; add_en = 1;
        pulse_start();
        wait_first(k);
        check("first_vld_latency", k, GAP + 2);
        check("first_a", din_a, 8'hE1);
        check("first_b", din_b, 8'h2B);
        wait_done(0);
        check("t1_pass", pass, 1);
        check("t1_err", err_cnt, 0);
        check("t1_ovf", ovf, 0);
        repeat (20) @(negedge clk);

        // 2: third result off by one
        bad_idx = nres + 2;
        pulse_start();
        wait_done(0);
        check("t2_err", err_cnt, 1);
        check("t2_pass", pass, 0);
        bad_idx = -1;
        repeat (20) @(negedge clk);

        // 3: latency beyond queue depth
        lat = 10;
        pulse_start();
        wait_done(0);
        check("t3_ovf", ovf, 1);
        check("t3_pass", pass, 0);
        check("t3_err_nonzero", err_cnt != 0, 1);
        repeat (30) @(negedge clk);

        // 4: no results at all -> drain timeout
        lat = 1; add_en = 0;
        pulse_start();
        wait_done(0);
        check("t4_err", err_cnt, 20);
        check("t4_ovf", ovf, 1);
        check("t4_pass", pass, 0);
        add_en = 1;
        repeat (10) @(negedge clk);

        // 5: stray result in IDLE, then a start during BURST
        pulse_start();   // flush prior err state with a clean run
        wait_done(0);
        repeat (10) @(negedge clk);
        inj = 1'b1; @(negedge clk); inj = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_err_idle", err_cnt, 1);
        pulse_start();
        check("t5_err_cleared", err_cnt, 0);
        wait_first(k);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done(0);
        check("t5_pass", pass, 1);
        check("t5_err", err_cnt, 0);
        repeat (10) @(negedge clk);

        // 6: reset at the 5th din_vld
        pulse_start();
        nv = 0;
        for (int i = 0; i < 300 && nv < 5; i++) begin
            if (din_vld) nv++;
            if (nv < 5) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1 check("t6_reset_now", {din_vld, din_a, din_b, busy, done, pass, ovf, err_cnt}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start();
        wait_first(k);
        check("t6_replay_a", din_a, 8'hE1);
        check("t6_replay_b", din_b, 8'h2B);
        wait_done(0);
        check("t6_pass", pass, 1);
        repeat (10) @(negedge clk);

        // 7: randomized latency, corruption and ignored start pulses
        for (int r = 0; r < 4; r++) begin
            lat = $urandom_range(1, 6);
            bad_idx = nres + $urandom_range(0, 25);
            repeat ($urandom_range(1, 8)) @(negedge clk);
            pulse_start();
            wait_done(1);
            repeat (20) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
